// File: rtl/rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter
//
// Shares one synchronous ID/password ROM between two requesters
// (port 0: user-ID controller, port 1: password controller).
// One access is granted at a time.
//
// For each access the arbiter:
//   - drives the registered ROM address,
//   - waits out ROM_LAT cycles,
//   - captures rom_q_i,
//   - returns the word to the owner with a one-cycle acknowledge.
//
// Arbitration is round-robin. A port is not considered in the IDLE cycle in
// which its own ack is high, so the requester has one cycle to drop its
// request or present a new address. The other port may be granted in that
// cycle.
//
// Optional feature macro: ROM_ARB_LOCK_EN
//   Defined:   while the current owner's lock input is high in IDLE, the other
//              port is ignored. The owner keeps the ROM across a multi-digit
//              burst. After the owner's ack cycle, its next request is granted
//              on the following cycle. A low lock seen in IDLE releases the
//              lock.
//   Undefined: lock0_i/lock1_i are ignored and arbitration is pure round-robin.
//
// Parameters
//   ADDR_W   ROM address width
//   DATA_W   ROM data width (one digit)
//   ROM_LAT  wait cycles between driving rom_addr_o and sampling rom_q_i (>=1)
//
// Ports
//   clk_i               system clock, rising edge
//   rst_i               synchronous active-high reset
//   req0_i / req1_i     access request, held until ack of the same port
//   addr0_i / addr1_i   requested address, stable while the request is high
//   lock0_i / lock1_i   keep ownership across consecutive accesses
//   ack0_o / ack1_o     one-cycle pulse: data valid
//   data0_o / data1_o   captured ROM word, held until the next ack to that port
//   rom_addr_o          registered ROM address
//   rom_q_i             ROM output
//   busy_o              high whenever the arbiter is not idle
//   owner_o             port currently or most recently granted
// -----------------------------------------------------------------------------
module rom_access_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              lock0_i,
  input  logic              lock1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_q_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam int CNT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CATCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic                busy_q, busy_d;

  logic                elig0_s;
  logic                elig1_s;
  logic                grant_s;
  logic                win_s;

`ifdef ROM_ARB_LOCK_EN
  logic                lock_own_s;
  assign lock_own_s = owner_q ? lock1_i : lock0_i;
`else
  logic                unused_lock_s;
  assign unused_lock_s = lock0_i ^ lock1_i;
`endif

  // Request eligibility (ack-cycle exclusion, optional lock) and winner pick
  always_comb begin
    // A port whose ack is showing this cycle still has its old request up.
    elig0_s = req0_i & ~ack0_q;
    elig1_s = req1_i & ~ack1_q;
`ifdef ROM_ARB_LOCK_EN
    // A locked owner shuts the other port out entirely while idle.
    if (lock_own_s) begin
      if (owner_q) begin
        elig0_s = 1'b0;
      end else begin
        elig1_s = 1'b0;
      end
    end else begin
      elig0_s = elig0_s;
    end
`endif
    grant_s = elig0_s | elig1_s;
    // On a tie, the port that did not win last time goes next.
    if (elig0_s && elig1_s) begin
      win_s = ~last_q;
    end else begin
      win_s = elig1_s;
    end
  end

  // Next-state and output computation for the IDLE/WAIT/CATCH sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    owner_d    = owner_q;
    last_d     = last_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    data0_d    = data0_q;
    data1_d    = data1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d    = ST_WAIT;
          cnt_d      = '0;
          rom_addr_d = win_s ? addr1_i : addr0_i;
          owner_d    = win_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // The counter runs 0..ROM_LAT-1 in WAIT, so WAIT lasts ROM_LAT cycles.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROM_LAT - 1)) begin
          state_d = ST_CATCH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CATCH: begin
        if (owner_q) begin
          ack1_d  = 1'b1;
          data1_d = rom_q_i;
        end else begin
          ack0_d  = 1'b1;
          data0_d = rom_q_i;
        end
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign data0_o    = data0_q;
  assign data1_o    = data1_q;
  assign rom_addr_o = rom_addr_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// Scoreboard testbench for rom_access_arbiter.
//
// A transaction-level reference model predicts every grant from the
// arbitration rules: which port wins, when the arbiter is free again, and
// when the ack appears. Each prediction is queued.
//
// A separate monitor, sampling 1 time unit after each rising edge, pops the
// queue whenever an ack appears. It compares port, cycle, data, ROM address
// and owner. It also checks busy and the held data words every cycle.
//
// Build with +define+ROM_ARB_LOCK_EN to exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_rom_access_arbiter;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 4;
  localparam int ROM_LAT = 2;
`ifdef ROM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              ack0, ack1, busy, owner;
  logic [DATA_W-1:0] data0, data1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q = '0;

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rom_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1),
    .lock0_i(lock0), .lock1_i(lock1),
    .ack0_o(ack0), .ack1_o(ack1),
    .data0_o(data0), .data1_o(data1),
    .rom_addr_o(rom_addr), .rom_q_i(rom_q),
    .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_q <= rom[rom_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model and scoreboard queue ----------------
  typedef struct {
    int                port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb_q[$];

  int free_cyc = 0;   // first cycle in which the arbiter can grant again
  int ack_cyc  = -1;  // cycle in which the last granted access acks
  int ack_port = 0;
  int last_win = 1;
  int own      = 0;
  int busy_lo  = 1;   // busy is expected high in cycles busy_lo..busy_hi
  int busy_hi  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies the arbitration rules to the inputs presented in cycle cyc.
  task automatic model_eval();
    bit   e0, e1;
    int   w;
    exp_t x;
    if (rst) begin
      sb_q.delete();
      free_cyc = cyc + 1;
      ack_cyc  = -1;
      last_win = 1;
      own      = 0;
      busy_lo  = 1;
      busy_hi  = 0;
      return;
    end
    if (cyc < free_cyc) return;
    e0 = req0 && !(cyc == ack_cyc && ack_port == 0);
    e1 = req1 && !(cyc == ack_cyc && ack_port == 1);
    if (LOCK_EN && ((own == 1) ? lock1 : lock0)) begin
      if (own == 1) e0 = 1'b0;
      else          e1 = 1'b0;
    end
    if (!e0 && !e1) return;
    w = (e0 && e1) ? (1 - last_win) : (e1 ? 1 : 0);
    x.port = w;
    x.addr = (w == 1) ? addr1 : addr0;
    x.data = rom[x.addr];
    x.cyc  = cyc + ROM_LAT + 2;
    sb_q.push_back(x);
    own      = w;
    last_win = w;
    free_cyc = x.cyc;
    ack_cyc  = x.cyc;
    ack_port = w;
    busy_lo  = cyc + 1;
    busy_hi  = cyc + ROM_LAT + 1;
  endtask

  // Called at a falling edge after inputs are set: model this cycle, advance.
  task automatic tick();
    model_eval();
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic [DATA_W-1:0] held0 = '0;
  logic [DATA_W-1:0] held1 = '0;

  initial begin
    exp_t x;
    int   p;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        held0 = '0;
        held1 = '0;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_data0", data0, 0);
        chk("rst_data1", data1, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        continue;
      end
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (ack0 && ack1) begin
        chk("both_acks", 1, 0);
      end else if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", p + 10, 0);
        end else begin
          x = sb_q.pop_front();
          chk("ack_port", p, x.port);
          chk("ack_cycle", cyc, x.cyc);
          chk("ack_data", (p == 1) ? data1 : data0, x.data);
          chk("ack_rom_addr", rom_addr, x.addr);
          chk("ack_owner", owner, x.port);
          if (x.port == 1) held1 = x.data;
          else             held0 = x.data;
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        x = sb_q.pop_front();
        chk("missing_ack", 0, x.port + 10);
      end
      chk("held_data0", data0, held0);
      chk("held_data1", data1, held1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, t0, t1, got, prev, c0, c1, alt_bad, first, n1, between, after0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = DATA_W'($urandom_range(0, 15));
    rom[5] = 4'hA;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single read of address 5: ack four cycles after the request.
    t0 = cyc; req0 = 1'b1; addr0 = 5'd5; n = 0;
    do begin tick(); n++; end while (!ack0 && n < 20);
    chk("single_latency", cyc - t0, ROM_LAT + 2);
    chk("single_data", data0, 4'hA);
    req0 = 1'b0;
    repeat (3) tick();

    // Reset in the middle of WAIT: access dropped, no ack afterwards.
    req1 = 1'b1; addr1 = 5'd3;
    tick(); tick();
    rst = 1'b1; req1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();

    // Tie from reset, then ten accesses under constant contention.
    req0 = 1'b1; addr0 = 5'd0; req1 = 1'b1; addr1 = 5'd8;
    n = 0; got = 0; prev = -1; c0 = 0; c1 = 0; alt_bad = 0; first = -1; t1 = 0;
    while (got < 10 && n < 200) begin
      if (ack0 || ack1) begin
        if (got == 0) begin first = ack1 ? 1 : 0; t1 = cyc; end
        if (got == 1) chk("tie_gap", cyc - t1, ROM_LAT + 2);
        if ((ack1 ? 1 : 0) == prev) alt_bad++;
        prev = ack1 ? 1 : 0;
        got++;
        if (ack1) begin c1++; addr1 = ADDR_W'($urandom); end
        else      begin c0++; addr0 = ADDR_W'($urandom); end
      end
      tick(); n++;
    end
    chk("tie_first", first, 0);
    chk("fair_port0", c0, 5);
    chk("fair_port1", c1, 5);
    chk("alternation", alt_bad, 0);
    req0 = 1'b0; req1 = 1'b0;   // in-flight access must still complete
    repeat (8) tick();

    // Burst of addresses 4..7 from port 1 with lock1 high while port 0 waits.
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; addr0 = 5'd1; req1 = 1'b1; addr1 = 5'd4; lock1 = 1'b1;
    n = 0; n1 = 0; between = 0; after0 = 0;
    while (after0 == 0 && n < 200) begin
      if (ack1) begin
        n1++;
        if (n1 < 4) addr1 = addr1 + 5'd1;
        else begin req1 = 1'b0; lock1 = 1'b0; end
      end
      if (ack0) begin
        if (n1 >= 1 && n1 < 4) between++;
        if (n1 == 4) after0 = 1;
        addr0 = ADDR_W'($urandom);
      end
      tick(); n++;
    end
    chk("burst_len", n1, 4);
    chk("burst_interleave", between, LOCK_EN ? 0 : 3);
    chk("ack0_after_burst", after0, 1);
    req0 = 1'b0;
    repeat (8) tick();

    // Randomized traffic with random locks and occasional resets.
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (ack0) begin
        if ($urandom_range(0, 1) == 1) req0 = 1'b0;
        else addr0 = ADDR_W'($urandom);
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; addr0 = ADDR_W'($urandom);
      end
      if (ack1) begin
        if ($urandom_range(0, 1) == 1) req1 = 1'b0;
        else addr1 = ADDR_W'($urandom);
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; addr1 = ADDR_W'($urandom);
      end
      if ($urandom_range(0, 7) == 0) lock0 = ~lock0;
      if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
      tick();
    end

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    repeat (10) tick();
    chk("drain_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
